// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds, sticky error flags
// and selectable FWFT read. Define SYNC_FIFO_HWM_EN to add the hwm high-water-mark output.
module sync_fifo_flex #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
`ifdef SYNC_FIFO_HWM_EN
    ,
    output logic [ADDR_WIDTH:0]   hwm
`endif
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_L    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_L    = AE_LEVEL[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // The extra wrap bit on each pointer lets level distinguish full from empty.
    assign level        = wptr - rptr;
    assign full         = (level == DEPTH_L);
    assign empty        = (level == '0);
    assign almost_full  = (level >= AF_L);
    assign almost_empty = (level <= AE_L);

    assign wr_ok = winc & ~full;
    assign rd_ok = rinc & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc & full)  overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (rinc & empty)  underflow <= 1'b1;
            else if (clr_err)  underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = mem[rptr[ADDR_WIDTH-1:0]];
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (rst)        rdata <= '0;
                else if (rd_ok) rdata <= mem[rptr[ADDR_WIDTH-1:0]];
            end
        end
    endgenerate

`ifdef SYNC_FIFO_HWM_EN
    logic [ADDR_WIDTH:0] level_nxt;

    always_comb begin
        level_nxt = level;
        if (wr_ok && !rd_ok)      level_nxt = level + 1'b1;
        else if (rd_ok && !wr_ok) level_nxt = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || clr_err)       hwm <= '0;
        else if (level_nxt > hwm) hwm <= level_nxt;
    end
`endif

endmodule
